mlp_engine: RTL and testbench

Parametrised two-layer perceptron engine for drowsiness classification, the generalised successor to the fixed 30-5-3 detector. It runs a sequential single-MAC forward pass over N_IN features, N_HID hidden neurons and N_OUT outputs in signed fixed point. It can optionally follow the forward pass with one delta-rule update of the output-layer weights. It sits between the feature extractor, which supplies in_data, and the classifier decision logic, which consumes out_data.

---
 rtl/mlp_pkg.sv | 52 +++++
 rtl/mlp_sigmoid.sv | 40 ++++
 rtl/mlp_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_mlp_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared state encoding and fixed-point helpers for the MLP engine.
package mlp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HID_MAC,
        S_HID_ACT,
        S_OUT_MAC,
        S_OUT_ACT,
        S_UPD_DELTA,
        S_UPD_APPLY,
        S_DONE
    } state_t;

    // PLAN breakpoints/offsets in units of 1/32, rescaled to FRAC where used.
    localparam int PLAN_SCALE_FRAC = 5;
    localparam int PLAN_BP_HI      = 160;
    localparam int PLAN_BP_MID     = 76;
    localparam int PLAN_BP_LO      = 32;
    localparam int PLAN_OFF_HI     = 27;
    localparam int PLAN_OFF_MID    = 20;
    localparam int PLAN_OFF_LO     = 16;

    function automatic int q_one(input int frac);
        return 1 << frac;
    endfunction

    function automatic int plan_q(input int v32, input int frac);
        return v32 << (frac - PLAN_SCALE_FRAC);
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (x > hi)
            return hi;
        if (x < lo)
            return lo;
        return x;
    endfunction

endpackage

// File: rtl/mlp_sigmoid.sv
// Combinational PLAN sigmoid approximation on a signed Q(DW-FRAC).FRAC value.
module mlp_sigmoid
    import mlp_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic signed [DW-1:0] x,
    output logic signed [DW-1:0] y
);
    localparam logic [DW:0] ONE_V   = (DW+1)'(q_one(FRAC));
    localparam logic [DW:0] BP_HI   = (DW+1)'(plan_q(PLAN_BP_HI, FRAC));
    localparam logic [DW:0] BP_MID  = (DW+1)'(plan_q(PLAN_BP_MID, FRAC));
    localparam logic [DW:0] BP_LO   = (DW+1)'(plan_q(PLAN_BP_LO, FRAC));
    localparam logic [DW:0] OFF_HI  = (DW+1)'(plan_q(PLAN_OFF_HI, FRAC));
    localparam logic [DW:0] OFF_MID = (DW+1)'(plan_q(PLAN_OFF_MID, FRAC));
    localparam logic [DW:0] OFF_LO  = (DW+1)'(plan_q(PLAN_OFF_LO, FRAC));

    logic signed [DW:0] xe;
    logic [DW:0] a;
    logic [DW:0] f;
    logic [DW:0] r;

    // One extra bit so |most-negative| is representable.
    always_comb begin
        xe = {x[DW-1], x};
        a  = xe[DW] ? unsigned'(-xe) : unsigned'(xe);
        if (a >= BP_HI)
            f = ONE_V;
        else if (a >= BP_MID)
            f = (a >> 5) + OFF_HI;
        else if (a >= BP_LO)
            f = (a >> 3) + OFF_MID;
        else
            f = (a >> 2) + OFF_LO;
        r = xe[DW] ? ONE_V - f : f;
        y = signed'(r[DW-1:0]);
    end

endmodule

// File: rtl/mlp_engine.sv
// Sequential single-MAC two-layer perceptron with an optional delta-rule
// update of the output-layer weights after the forward pass.
module mlp_engine
    import mlp_pkg::*;
#(
    parameter int DW          = 16,
    parameter int FRAC        = 8,
    parameter int N_IN        = 30,
    parameter int N_HID       = 5,
    parameter int N_OUT       = 3,
    parameter int LR_SHIFT    = 0,
    parameter int CONV_THRESH = 4,
    localparam int NW = N_HID*N_IN + N_OUT*N_HID,
    localparam int AW = clog2(NW)
) (
    input  logic                 Clock,
    input  logic                 Rst,
    input  logic                 start,
    input  logic                 train,
    input  logic [N_IN*DW-1:0]   in_data,
    input  logic [N_OUT*DW-1:0]  target,
    input  logic                 wt_we,
    input  logic [AW-1:0]        wt_addr,
    input  logic [DW-1:0]        wt_wdata,
    output logic [DW-1:0]        wt_rdata,
    output logic                 busy,
    output logic                 out_valid,
    output logic [N_OUT*DW-1:0]  out_data,
    output logic [N_HID*DW-1:0]  out_hid,
    output logic                 converged
);
    localparam int ACC_W  = 2*DW + clog2(N_IN);
    localparam int WIDE   = 64;
    localparam int CW     = clog2(N_IN + N_HID + 1);
    localparam int HXW    = clog2(N_HID);
    localparam int OXW    = clog2(N_OUT);
    localparam int V_BASE = N_HID*N_IN;

    state_t state_reg, state_next;
    logic [CW-1:0] idx_reg, idx_next;
    logic [CW-1:0] nrn_reg, nrn_next;
    logic signed [ACC_W-1:0] acc_reg;
    logic train_reg, conv_reg;
    logic signed [WIDE-1:0] delta_reg;
    logic [N_IN*DW-1:0]  x_vec_reg;
    logic [N_OUT*DW-1:0] tgt_vec_reg;
    logic signed [DW-1:0] wmem [NW];
    logic signed [DW-1:0] hid_reg [N_HID];
    logic signed [DW-1:0] y_reg [N_OUT];
    logic signed [DW-1:0] out_hid_reg [N_HID];
    logic signed [DW-1:0] out_y_reg [N_OUT];

    logic accept, wr_ok, load_out, delta_small;
    logic [AW-1:0] w_idx;
    logic signed [DW-1:0] mac_a, mac_b, sig_in, sig_out;
    logic signed [2*DW-1:0] prod;
    logic signed [WIDE-1:0] y_w, e_w, d_w, delta_w, delta_abs, upd_w;

    assign accept   = (state_reg == S_IDLE) && start;
    assign wr_ok    = (state_reg == S_IDLE) && wt_we && (int'(wt_addr) < NW);
    assign load_out = (state_next == S_DONE) && (state_reg != S_DONE);

    always_comb begin
        mac_a     = '0;
        w_idx     = '0;
        y_w       = '0;
        e_w       = '0;
        d_w       = '0;
        delta_w   = '0;
        upd_w     = '0;
        case (state_reg)
            S_HID_MAC: begin
                mac_a = x_vec_reg[int'(idx_reg)*DW +: DW];
                w_idx = AW'(int'(nrn_reg)*N_IN + int'(idx_reg));
            end
            S_OUT_MAC, S_UPD_APPLY: begin
                mac_a = hid_reg[idx_reg[HXW-1:0]];
                w_idx = AW'(V_BASE + int'(nrn_reg)*N_HID + int'(idx_reg));
                upd_w = (delta_reg * WIDE'(mac_a)) >>> FRAC;
            end
            S_UPD_DELTA: begin
                y_w     = WIDE'(y_reg[nrn_reg[OXW-1:0]]);
                e_w     = WIDE'(signed'(tgt_vec_reg[int'(nrn_reg)*DW +: DW])) - y_w;
                d_w     = (y_w * (WIDE'(q_one(FRAC)) - y_w)) >>> FRAC;
                delta_w = ((e_w * d_w) >>> FRAC) >>> LR_SHIFT;
            end
            default: ;
        endcase
        mac_b       = wmem[w_idx];
        prod        = (2*DW)'(mac_a) * (2*DW)'(mac_b);
        sig_in      = DW'(sat(WIDE'(acc_reg >>> FRAC), DW));
        delta_abs   = delta_w[WIDE-1] ? -delta_w : delta_w;
        delta_small = delta_abs < WIDE'(CONV_THRESH);
    end

    mlp_sigmoid #(.DW(DW), .FRAC(FRAC)) u_sigmoid (
        .x (sig_in),
        .y (sig_out)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        nrn_next   = nrn_reg;
        case (state_reg)
            S_IDLE: if (start) begin
                state_next = S_HID_MAC;
                idx_next   = '0;
                nrn_next   = '0;
            end
            S_HID_MAC: if (idx_reg == CW'(N_IN-1)) begin
                state_next = S_HID_ACT;
                idx_next   = '0;
            end else
                idx_next = idx_reg + CW'(1);
            S_HID_ACT: begin
                state_next = (nrn_reg == CW'(N_HID-1)) ? S_OUT_MAC : S_HID_MAC;
                nrn_next   = (nrn_reg == CW'(N_HID-1)) ? '0 : nrn_reg + CW'(1);
            end
            S_OUT_MAC: if (idx_reg == CW'(N_HID-1)) begin
                state_next = S_OUT_ACT;
                idx_next   = '0;
            end else
                idx_next = idx_reg + CW'(1);
            S_OUT_ACT: if (nrn_reg == CW'(N_OUT-1)) begin
                state_next = train_reg ? S_UPD_DELTA : S_DONE;
                nrn_next   = '0;
            end else begin
                state_next = S_OUT_MAC;
                nrn_next   = nrn_reg + CW'(1);
            end
            S_UPD_DELTA: state_next = S_UPD_APPLY;
            S_UPD_APPLY: if (idx_reg == CW'(N_HID-1)) begin
                idx_next = '0;
                if (nrn_reg == CW'(N_OUT-1))
                    state_next = S_DONE;
                else begin
                    state_next = S_UPD_DELTA;
                    nrn_next   = nrn_reg + CW'(1);
                end
            end else
                idx_next = idx_reg + CW'(1);
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            nrn_reg   <= '0;
            acc_reg   <= '0;
            train_reg <= 1'b0;
            conv_reg  <= 1'b0;
            delta_reg <= '0;
            for (int k = 0; k < N_OUT; k++) out_y_reg[k] <= '0;
            for (int j = 0; j < N_HID; j++) out_hid_reg[j] <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            nrn_reg   <= nrn_next;
            case (state_reg)
                S_IDLE: if (start) begin
                    acc_reg   <= '0;
                    train_reg <= train;
                    conv_reg  <= train;
                end
                S_HID_MAC, S_OUT_MAC: acc_reg <= acc_reg + ACC_W'(prod);
                S_HID_ACT, S_OUT_ACT: acc_reg <= '0;
                S_UPD_DELTA: begin
                    delta_reg <= delta_w;
                    conv_reg  <= conv_reg & delta_small;
                end
                default: ;
            endcase
            // The last output is still on the sigmoid when an inference run finishes.
            if (load_out) begin
                for (int k = 0; k < N_OUT; k++)
                    out_y_reg[k] <= (state_reg == S_OUT_ACT && int'(nrn_reg) == k) ? sig_out : y_reg[k];
                for (int j = 0; j < N_HID; j++)
                    out_hid_reg[j] <= hid_reg[j];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (accept) begin
            x_vec_reg   <= in_data;
            tgt_vec_reg <= target;
        end
        if (state_reg == S_HID_ACT)
            hid_reg[nrn_reg[HXW-1:0]] <= sig_out;
        if (state_reg == S_OUT_ACT)
            y_reg[nrn_reg[OXW-1:0]] <= sig_out;
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int n = 0; n < NW; n++) wmem[n] <= '0;
        end else if (wr_ok) begin
            wmem[wt_addr] <= wt_wdata;
        end else if (state_reg == S_UPD_APPLY) begin
            wmem[w_idx] <= DW'(sat(WIDE'(mac_b) + upd_w, DW));
        end
    end

    assign wt_rdata  = (int'(wt_addr) < NW) ? wmem[wt_addr] : '0;
    assign busy      = (state_reg != S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign converged = out_valid & conv_reg;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out_data
        assign out_data[gi*DW +: DW] = out_y_reg[gi];
    end
    for (genvar gi = 0; gi < N_HID; gi++) begin : g_out_hid
        assign out_hid[gi*DW +: DW] = out_hid_reg[gi];
    end

endmodule

// File: tb/tb_mlp_engine.sv
// Directed bench for mlp_engine: sigmoid/forward vector table plus training,
// saturation, busy-protection and reset-abort sequences.
module tb_mlp_engine;
    localparam int DW    = 16;
    localparam int N_IN  = 30;
    localparam int N_HID = 5;
    localparam int N_OUT = 3;
    localparam int AW    = 8;
    localparam int VB    = N_HID*N_IN;

    logic Clock, Rst, start, train, wt_we, busy, out_valid, converged;
    logic [N_IN*DW-1:0]  in_data;
    logic [N_OUT*DW-1:0] target;
    logic [AW-1:0] wt_addr;
    logic [DW-1:0] wt_wdata, wt_rdata;
    logic [N_OUT*DW-1:0] out_data;
    logic [N_HID*DW-1:0] out_hid;

    int n_cmp = 0;
    int n_bad = 0;
    int conv_cap;

    typedef struct {
        int x0;
        int exp_h;
        int exp_y;
    } vec_t;
    vec_t vecs[13];

    mlp_engine dut (
        .Clock(Clock), .Rst(Rst), .start(start), .train(train),
        .in_data(in_data), .target(target), .wt_we(wt_we), .wt_addr(wt_addr),
        .wt_wdata(wt_wdata), .wt_rdata(wt_rdata), .busy(busy), .out_valid(out_valid),
        .out_data(out_data), .out_hid(out_hid), .converged(converged)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tb_plan(input int x);
        int a, f;
        a = (x < 0) ? -x : x;
        if (a >= 1280)     f = 256;
        else if (a >= 608) f = a / 32 + 216;
        else if (a >= 256) f = a / 8 + 160;
        else               f = a / 4 + 128;
        return (x < 0) ? 256 - f : f;
    endfunction

    task automatic wr_w(input int addr, input int data);
        @(negedge Clock);
        wt_we = 1'b1; wt_addr = AW'(addr); wt_wdata = DW'(data);
        @(negedge Clock);
        wt_we = 1'b0;
    endtask

    task automatic rd_check(input string name, input int addr, input int exp);
        wt_addr = AW'(addr);
        #1;
        check(name, longint'(signed'(wt_rdata)), exp);
    endtask

    // Runs one pass; optional write strobe goes out together with start.
    task automatic run(input logic t, input int exp_lat, input logic sim_we, input int sim_addr, input int sim_data);
        int cyc;
        logic [N_IN*DW-1:0] saved;
        saved = in_data;
        @(negedge Clock);
        start = 1'b1; train = t;
        wt_we = sim_we; wt_addr = AW'(sim_addr); wt_wdata = DW'(sim_data);
        @(negedge Clock);
        start = 1'b0; train = 1'b0; wt_we = 1'b0;
        in_data = ~saved;
        cyc = 1;
        check("busy_cycle1", busy, 1);
        while (!out_valid && cyc < 400) begin
            @(negedge Clock);
            cyc++;
        end
        check("latency", cyc, exp_lat);
        conv_cap = converged;
        @(negedge Clock);
        check("busy_fall", busy, 0);
        check("valid_one_cycle", out_valid, 0);
        in_data = saved;
    endtask

    task automatic check_outs(input string tag, input int h0, input int hr, input int yv, input int conv);
        for (int j = 0; j < N_HID; j++)
            check($sformatf("%s_h%0d", tag, j), longint'(signed'(out_hid[j*DW +: DW])), (j == 0) ? h0 : hr);
        for (int k = 0; k < N_OUT; k++)
            check($sformatf("%s_y%0d", tag, k), longint'(signed'(out_data[k*DW +: DW])), yv);
        check($sformatf("%s_conv", tag), conv_cap, conv);
        $display("run %s: h0=%0d h1=%0d y0=%0d conv=%0d", tag,
                 signed'(out_hid[0 +: DW]), signed'(out_hid[DW +: DW]), signed'(out_data[0 +: DW]), conv_cap);
    endtask

    initial begin
        int pulses, h0_cap;
        vecs[0]  = '{512, 224, 251};
        vecs[1]  = '{0, 128, 236};
        vecs[2]  = '{-512, 32, 168};
        vecs[3]  = '{1280, 256, 256};
        vecs[4]  = '{-1280, 0, 128};
        vecs[5]  = '{300, 197, 246};
        vecs[6]  = '{-100, 103, 224};
        vecs[7]  = '{608, 235, 252};
        vecs[8]  = '{607, 235, 252};
        vecs[9]  = '{255, 191, 245};
        vecs[10] = '{256, 192, 246};
        vecs[11] = '{1279, 255, 255};
        vecs[12] = '{-300, 59, 196};

        Rst = 1'b0; start = 1'b0; train = 1'b0; wt_we = 1'b0;
        wt_addr = '0; wt_wdata = '0; in_data = '0; target = '0;
        repeat (3) @(negedge Clock);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_conv", converged, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_hid", out_hid, 0);
        rd_check("rst_w0", 0, 0);
        $display("reset: busy=%0d out_valid=%0d", busy, out_valid);
        Rst = 1'b1;

        // Zero weights, inference.
        for (int i = 0; i < N_IN; i++) in_data[i*DW +: DW] = DW'(100*i - 1000);
        run(1'b0, 174, 1'b0, 0, 0);
        check_outs("zero_inf", 128, 128, 128, 0);

        // Training with zero error converges and leaves weights at 0.
        for (int k = 0; k < N_OUT; k++) target[k*DW +: DW] = 16'd128;
        run(1'b1, 192, 1'b0, 0, 0);
        check_outs("train_conv", 128, 128, 128, 1);
        rd_check("train_conv_v00", VB, 0);

        // Training towards 1.0: every output weight moves to 16.
        for (int k = 0; k < N_OUT; k++) target[k*DW +: DW] = 16'd256;
        run(1'b1, 192, 1'b0, 0, 0);
        check_outs("train", 128, 128, 128, 0);
        for (int n = 0; n < N_OUT*N_HID; n++)
            rd_check($sformatf("train_v%0d", n), VB + n, 16);
        for (int n = 0; n < VB; n += 7)
            rd_check($sformatf("train_w%0d", n), n, 0);

        // Table of forward vectors: w[j][0]=256, v=256, only x0 non-zero.
        for (int j = 0; j < N_HID; j++) wr_w(j*N_IN, 256);
        for (int n = 0; n < N_OUT*N_HID; n++) wr_w(VB + n, 256);
        rd_check("oob_read_200", 200, 0);
        rd_check("oob_read_165", 165, 0);
        in_data = '0;
        for (int v = 0; v < 13; v++) begin
            in_data[0 +: DW] = DW'(vecs[v].x0);
            run(1'b0, 174, 1'b0, 0, 0);
            check_outs($sformatf("vec%0d", v), vecs[v].exp_h, vecs[v].exp_h, vecs[v].exp_y, 0);
        end

        // Start and write while busy are both dropped.
        in_data[0 +: DW] = 16'd512;
        @(negedge Clock); start = 1'b1;
        @(negedge Clock); start = 1'b0;
        repeat (10) @(negedge Clock);
        wt_we = 1'b1; wt_addr = '0; wt_wdata = '0; start = 1'b1;
        @(negedge Clock);
        wt_we = 1'b0; start = 1'b0;
        rd_check("busy_wr_dropped", 0, 256);
        pulses = 0; h0_cap = 0;
        for (int c = 0; c < 450; c++) begin
            @(negedge Clock);
            if (out_valid) begin
                pulses++;
                h0_cap = signed'(out_hid[0 +: DW]);
            end
        end
        check("busy_single_valid", pulses, 1);
        check("busy_h0", h0_cap, 224);
        $display("busy test: pulses=%0d h0=%0d", pulses, h0_cap);

        // Write in the same cycle as start: the run sees the new weight.
        run(1'b0, 174, 1'b1, 0, 0);
        check_outs("sim_wr", 128, 224, 248, 0);

        // Saturating accumulator on neuron 0.
        for (int i = 0; i < N_IN; i++) wr_w(i, 32767);
        for (int j = 1; j < N_HID; j++) wr_w(j*N_IN, 0);
        for (int i = 0; i < N_IN; i++) in_data[i*DW +: DW] = 16'd32767;
        run(1'b0, 174, 1'b0, 0, 0);
        check_outs("sat", 256, 128, tb_plan((256*256 + 4*128*256) >>> 8), 0);
        check("sat_y_hand", signed'(out_data[0 +: DW]), 240);

        // Reset in the middle of HID_MAC aborts the run.
        @(negedge Clock); start = 1'b1;
        @(negedge Clock); start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge Clock);
            if (out_valid) pulses++;
        end
        Rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_hid", out_hid, 0);
        rd_check("abort_w0", 0, 0);
        rd_check("abort_v0", VB, 0);
        @(negedge Clock);
        Rst = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clock);
            if (out_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        run(1'b0, 174, 1'b0, 0, 0);
        check_outs("after_abort", 128, 128, 128, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
